// File: rtl/spi_reg_sequencer.sv
// Register-transaction sequencer in front of a byte-level SPI master: issues an address
// byte plus up to MAX_BYTES data bytes under one chip select, using a shared byte buffer.
module spi_reg_sequencer #(
  parameter int unsigned MAX_BYTES = 8,
  parameter int unsigned CS_DELAY  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [3:0] len,
  input  logic       wr_en,
  input  logic [3:0] wr_idx,
  input  logic [7:0] wr_byte,
  input  logic [3:0] rd_idx,
  output logic [7:0] rd_byte,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       spi_start,
  output logic [7:0] spi_data_in,
  input  logic       spi_busy,
  input  logic       spi_new_data,
  input  logic [7:0] spi_data_out
);

  localparam int unsigned CW = (CS_DELAY > 1) ? $clog2(CS_DELAY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CS_DELAY - 1);
  localparam logic [3:0]    MAX_LEN  = 4'(MAX_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SEND,
    S_WAIT,
    S_CS_HOLD,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      k_q, k_d;
  logic            rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic            cs_n_q, cs_n_d;
  logic            done_q, done_d;
  logic [7:0]      buf_q [MAX_BYTES];
  logic [7:0]      buf_d [MAX_BYTES];
  logic [7:0]      wr_src;
  logic            cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign cs_n     = cs_n_q;

  // Data byte k is sourced from / captured into buffer slot k-1 (slot 0 follows the address byte).
  always_comb begin
    wr_src = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (k_q == 4'(i + 1)) wr_src = buf_q[i];
    end
  end

  always_comb begin
    rd_byte = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (rd_idx == 4'(i)) rd_byte = buf_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cs_n_d      = cs_n_q;
    done_d      = 1'b0;
    buf_d       = buf_q;
    spi_start   = 1'b0;
    spi_data_in = '0;

    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (wr_idx == 4'(i)) buf_d[i] = wr_byte;
          end
        end
        if (req) begin
          rw_d    = rw;
          addr_d  = addr;
          len_d   = (len > MAX_LEN) ? MAX_LEN : len;
          k_d     = '0;
          cnt_d   = '0;
          cs_n_d  = 1'b0;
          state_d = S_CS_SETUP;
        end
      end

      S_CS_SETUP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SEND: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          if (k_q == '0)  spi_data_in = {rw_q, addr_q};
          else if (rw_q)  spi_data_in = '0;
          else            spi_data_in = wr_src;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (spi_new_data) begin
          if (rw_q && (k_q != '0)) begin
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
              if (k_q == 4'(i + 1)) buf_d[i] = spi_data_out;
            end
          end
          if (k_q == len_q) begin
            cnt_d   = '0;
            state_d = S_CS_HOLD;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_SEND;
          end
        end
      end

      S_CS_HOLD: begin
        if (cnt_last) begin
          cnt_d   = '0;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_GAP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < MAX_BYTES; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < MAX_BYTES; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: byte-engine/slave model, buffer reference model,
// vector table, hand-written corner sequences and randomized transactions.
module tb_spi_reg_sequencer;

  localparam int MAXB     = 8;
  localparam int CSD      = 4;
  localparam int BYTE_CYC = 3;
  localparam int STALL    = 5;

  logic       clk = 1'b0;
  logic       rst, req, rw, wr_en;
  logic [6:0] addr;
  logic [3:0] len, wr_idx, rd_idx;
  logic [7:0] wr_byte, rd_byte, spi_data_in, spi_data_out;
  logic       busy, done, cs_n, spi_start, spi_busy, spi_new_data;

  always #5 clk = ~clk;

  spi_reg_sequencer #(.MAX_BYTES(MAXB), .CS_DELAY(CSD)) dut (
    .clk(clk), .rst(rst), .req(req), .rw(rw), .addr(addr), .len(len),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_byte(wr_byte), .rd_idx(rd_idx), .rd_byte(rd_byte),
    .busy(busy), .done(done), .cs_n(cs_n), .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_busy(spi_busy), .spi_new_data(spi_new_data), .spi_data_out(spi_data_out)
  );

  int checks = 0;
  int failures = 0;
  int txn_no = 0;

  logic       stall_mode = 1'b0;
  logic [7:0] resp [16];
  logic [7:0] mbuf [MAXB];

  logic [7:0] eng_log [$];
  int         eng_viol = 0;

  // Byte engine + slave: takes a start, stays busy BYTE_CYC cycles, then pulses new_data
  // with the slave's byte for that position. In stall mode busy is held extra cycles.
  initial begin : engine
    int   cnt, stall, idx;
    logic st, bz, csn, prev_csn;
    logic [7:0] d;
    spi_busy = 1'b0; spi_new_data = 1'b0; spi_data_out = '0;
    cnt = 0; stall = 0; idx = 0; prev_csn = 1'b1;
    forever begin
      @(negedge clk);
      st = spi_start; bz = spi_busy; csn = cs_n; d = spi_data_in;
      @(posedge clk);
      #1;
      spi_new_data = 1'b0;
      if (csn) idx = 0;
      if (st) begin
        if (bz) eng_viol++;
        eng_log.push_back(d);
        cnt = BYTE_CYC;
        spi_busy = 1'b1;
      end else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) begin
          spi_new_data = 1'b1;
          spi_data_out = resp[idx % 16];
          idx++;
          if (stall_mode) stall = STALL;
          else spi_busy = 1'b0;
        end
      end else if (stall != 0) begin
        stall--;
        if (stall == 0) spi_busy = 1'b0;
      end else if (stall_mode && prev_csn && !csn) begin
        spi_busy = 1'b1;
        stall = STALL;
      end
      prev_csn = csn;
    end
  end

  int done_cnt = 0, last_cs_low = 0, min_gap = 1 << 20, cs_run = 0, hi_run = 0;
  bit seen_low = 1'b0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (cs_n === 1'b0) begin
        if (seen_low && hi_run != 0 && hi_run < min_gap) min_gap = hi_run;
        seen_low = 1'b1; hi_run = 0; cs_run++;
      end else begin
        if (cs_run != 0) last_cs_low = cs_run;
        cs_run = 0; hi_run++;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] logbyte(input int idx);
    if (idx < eng_log.size()) return 32'(eng_log[idx]);
    return 32'hFFFF_FFFF;
  endfunction

  task automatic host_write(input int idx, input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = 4'(idx); wr_byte = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (idx < MAXB) mbuf[idx] = b;
  endtask

  task automatic check_buf(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      rd_idx = 4'(i);
      #1;
      chk($sformatf("%s rd_byte[%0d]", tag, i), 32'(rd_byte), (i < MAXB) ? 32'(mbuf[i]) : 32'h0);
    end
  endtask

  task automatic run_txn(input logic rw_i, input logic [6:0] addr_i, input logic [3:0] len_i,
                         input bit timed, output int starts, output int base, output int cs_low);
    int c, n, d0;
    logic [7:0] exp_bytes [$];
    string t;
    txn_no++;
    t = $sformatf("txn%0d", txn_no);
    n = (int'(len_i) > MAXB) ? MAXB : int'(len_i);
    exp_bytes.push_back({rw_i, addr_i});
    for (int j = 0; j < n; j++) exp_bytes.push_back(rw_i ? 8'h00 : mbuf[j]);

    @(negedge clk);
    c = 0;
    while (busy && c < 300) begin @(negedge clk); c++; end
    chk({t, " idle before req"}, 32'(busy), 32'h0);
    base = eng_log.size();
    d0 = done_cnt;
    req = 1'b1; rw = rw_i; addr = addr_i; len = len_i;
    @(negedge clk);
    req = 1'b0;
    chk({t, " accept cs_n"}, 32'(cs_n), 32'h0);
    chk({t, " accept busy"}, 32'(busy), 32'h1);
    c = 0;
    while (!spi_start && c < 400) begin @(negedge clk); c++; end
    if (timed) chk({t, " setup cycles"}, 32'(c), 32'(CSD));
    c = 0;
    while (!done && c < 3000) begin @(negedge clk); c++; end
    chk({t, " done seen"}, 32'(done), 32'h1);
    chk({t, " cs_n high at done"}, 32'(cs_n), 32'h1);
    c = 0;
    while (busy && c < 300) begin @(negedge clk); c++; end
    if (timed) chk({t, " gap cycles"}, 32'(c), 32'(CSD));
    @(negedge clk);
    chk({t, " done pulses"}, 32'(done_cnt - d0), 32'h1);
    starts = eng_log.size() - base;
    for (int j = 0; j < exp_bytes.size(); j++)
      chk($sformatf("%s byte%0d", t, j), logbyte(base + j), 32'(exp_bytes[j]));
    cs_low = last_cs_low;
    if (rw_i) for (int j = 0; j < n; j++) mbuf[j] = resp[j + 1];
  endtask

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [3:0] len;
    int         exp_starts;
    logic [7:0] exp_first;
    int         exp_cs_low;
  } vec_t;

  initial begin : main
    vec_t vecs [7];
    int starts, base, cs_low, c, d0, lows, v0, n;
    logic [3:0] ln;

    rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; len = '0;
    wr_en = 1'b0; wr_idx = '0; wr_byte = '0; rd_idx = '0;
    for (int i = 0; i < MAXB; i++) mbuf[i] = '0;
    for (int j = 0; j < 16; j++) resp[j] = 8'(j * 37 + 5);

    vecs[0] = '{1'b0, 7'h00, 4'd0,  1, 8'h00, 13};
    vecs[1] = '{1'b1, 7'h7F, 4'd15, 9, 8'hFF, 53};
    vecs[2] = '{1'b0, 7'h40, 4'd8,  9, 8'h40, 53};
    vecs[3] = '{1'b1, 7'h01, 4'd9,  9, 8'h81, 53};
    vecs[4] = '{1'b0, 7'h2A, 4'd1,  2, 8'h2A, 18};
    vecs[5] = '{1'b1, 7'h10, 4'd0,  1, 8'h90, 13};
    vecs[6] = '{1'b0, 7'h55, 4'd7,  8, 8'h55, 48};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset cs_n", 32'(cs_n), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset spi_start", 32'(spi_start), 32'h0);
    chk("reset spi_data_in", 32'(spi_data_in), 32'h0);
    check_buf("reset");

    // Write 3 bytes from a preloaded buffer
    host_write(0, 8'hA1); host_write(1, 8'hB2); host_write(2, 8'hC3);
    run_txn(1'b0, 7'h1B, 4'd3, 1'b1, starts, base, cs_low);
    chk("wr3 starts", 32'(starts), 32'd4);
    chk("wr3 b0", logbyte(base), 32'h1B);
    chk("wr3 b1", logbyte(base + 1), 32'hA1);
    chk("wr3 b2", logbyte(base + 2), 32'hB2);
    chk("wr3 b3", logbyte(base + 3), 32'hC3);
    chk("wr3 cs low", 32'(cs_low), 32'd28);
    check_buf("wr3");

    // Read 2 bytes
    resp[1] = 8'h5A; resp[2] = 8'h3C;
    run_txn(1'b1, 7'h75, 4'd2, 1'b1, starts, base, cs_low);
    chk("rd2 starts", 32'(starts), 32'd3);
    chk("rd2 b0", logbyte(base), 32'hF5);
    chk("rd2 b1", logbyte(base + 1), 32'h00);
    chk("rd2 b2", logbyte(base + 2), 32'h00);
    @(negedge clk); rd_idx = 4'd0; #1; chk("rd2 rd_byte0", 32'(rd_byte), 32'h5A);
    @(negedge clk); rd_idx = 4'd1; #1; chk("rd2 rd_byte1", 32'(rd_byte), 32'h3C);
    check_buf("rd2");

    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 16; j++) resp[j] = 8'(j * 29 + i * 7 + 1);
      run_txn(vecs[i].rw, vecs[i].addr, vecs[i].len, 1'b1, starts, base, cs_low);
      chk($sformatf("vec%0d starts", i), 32'(starts), 32'(vecs[i].exp_starts));
      chk($sformatf("vec%0d first byte", i), logbyte(base), 32'(vecs[i].exp_first));
      chk($sformatf("vec%0d cs low", i), 32'(cs_low), 32'(vecs[i].exp_cs_low));
      check_buf($sformatf("vec%0d", i));
    end

    // Reset during byte 2 of a read
    for (int j = 0; j < 16; j++) resp[j] = 8'(8'hE0 + j);
    base = eng_log.size();
    d0 = done_cnt;
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = 7'h22; len = 4'd4;
    @(negedge clk);
    req = 1'b0;
    c = 0;
    while (eng_log.size() < base + 3 && c < 300) begin @(negedge clk); c++; end
    chk("rstmid reached byte2", 32'(eng_log.size() >= base + 3), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid cs_n", 32'(cs_n), 32'h1);
    chk("rstmid busy", 32'(busy), 32'h0);
    chk("rstmid done", 32'(done), 32'h0);
    for (int i = 0; i < MAXB; i++) mbuf[i] = '0;
    repeat (12) @(negedge clk);
    chk("rstmid no done", 32'(done_cnt - d0), 32'h0);
    check_buf("rstmid");
    run_txn(1'b1, 7'h3E, 4'd3, 1'b1, starts, base, cs_low);
    chk("after rst starts", 32'(starts), 32'd4);
    check_buf("after rst");

    // Host write and req while busy, both mid-transaction and in the gap
    host_write(0, 8'h11); host_write(1, 8'h22); host_write(2, 8'h33);
    base = eng_log.size();
    d0 = done_cnt;
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 7'h33; len = 4'd2;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    wr_en = 1'b1; wr_idx = 4'd0; wr_byte = 8'hEE; req = 1'b1; rw = 1'b1; len = 4'd8;
    @(negedge clk);
    wr_en = 1'b0; req = 1'b0;
    c = 0;
    while (!done && c < 3000) begin @(negedge clk); c++; end
    chk("prot done seen", 32'(done), 32'h1);
    wr_en = 1'b1; wr_idx = 4'd1; wr_byte = 8'hDD; req = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; req = 1'b0;
    c = 0;
    while (busy && c < 300) begin @(negedge clk); c++; end
    lows = 0;
    repeat (10) begin @(negedge clk); if (cs_n !== 1'b1 || busy !== 1'b0) lows++; end
    chk("prot no second txn", 32'(lows), 32'h0);
    chk("prot starts", 32'(eng_log.size() - base), 32'd3);
    chk("prot b1", logbyte(base + 1), 32'h11);
    chk("prot done pulses", 32'(done_cnt - d0), 32'h1);
    check_buf("prot");

    // Length clamp with engine stalls before every byte
    v0 = eng_viol;
    stall_mode = 1'b1;
    run_txn(1'b0, 7'h5C, 4'd12, 1'b0, starts, base, cs_low);
    stall_mode = 1'b0;
    chk("stall starts", 32'(starts), 32'd9);
    chk("stall start while busy", 32'(eng_viol - v0), 32'h0);
    chk("stall lengthened cs", 32'(cs_low > 53), 32'h1);
    repeat (10) @(negedge clk);
    check_buf("stall");

    // Randomized transactions against the buffer model
    for (int t = 0; t < 12; t++) begin
      n = $urandom_range(0, 5);
      for (int w = 0; w < n; w++) host_write($urandom_range(0, 15), 8'($urandom));
      for (int j = 0; j < 16; j++) resp[j] = 8'($urandom);
      ln = 4'($urandom_range(0, 15));
      run_txn(1'($urandom_range(0, 1)), 7'($urandom), ln, 1'b1, starts, base, cs_low);
      n = (int'(ln) > MAXB) ? MAXB + 1 : int'(ln) + 1;
      chk($sformatf("rand%0d starts", t), 32'(starts), 32'(n));
      chk($sformatf("rand%0d cs low", t), 32'(cs_low), 32'(2 * CSD + n * (BYTE_CYC + 2)));
      check_buf($sformatf("rand%0d", t));
    end

    chk("min cs_n high gap", 32'(min_gap >= CSD), 32'h1);
    chk("engine start while busy", 32'(eng_viol), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_sequencer.md
# spi_reg_sequencer

Register-transaction sequencer sitting directly upstream of the team's byte-level SPI master (CPOL=1, CPHA=0). It accepts one host request, consisting of a register address, a direction and a byte count, and owns chip select. It drives the byte engine through its `start`/`busy`/`new_data` handshake: one address byte, then up to MAX_BYTES data bytes. Write data comes from an internal byte buffer, and read data is captured into the same buffer.

## Interface
- MAX_BYTES, 8: buffer depth and max data bytes per transaction (1..15).
- CS_DELAY, 4: clk cycles for each of cs_n setup, cs_n hold and minimum cs_n high gap (>=1).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  start transaction; sampled only when busy=0.
- rw  in  1  1=read, 0=write; latched with req.
- addr  in  7  register address; latched with req.
- len  in  4  data-byte count; latched with req; values >MAX_BYTES clamp to MAX_BYTES; 0 = address-only transaction.
- wr_en  in  1  host buffer write; ignored while busy=1.
- wr_idx  in  4  buffer index for wr_en; idx>=MAX_BYTES ignored.
- wr_byte  in  8  buffer write data.
- rd_idx  in  4  buffer read index.
- rd_byte  out  8  buf[rd_idx], combinational; 0 when rd_idx>=MAX_BYTES.
- busy  out  1  high from the cycle after req acceptance until return to IDLE.
- done  out  1  one-cycle pulse at transaction end.
- cs_n  out  1  slave select, registered, active-low.
- spi_start  out  1  to byte engine `start`.
- spi_data_in  out  8  to byte engine `data_in`.
- spi_busy  in  1  from byte engine `busy`.
- spi_new_data  in  1  from byte engine `new_data`.
- spi_data_out  in  8  from byte engine `data_out`.

## Operation
- States: IDLE, CS_SETUP, SEND, WAIT, CS_HOLD, GAP.
- IDLE: cs_n=1, busy=0. When req=1, latch rw, addr and clamped len (len_q). Clear byte index k and the delay counter, drive cs_n to 0, and go to CS_SETUP.
- CS_SETUP: count CS_DELAY cycles, then go to SEND.
- SEND: when spi_busy=0, assert spi_start for exactly one cycle and go to WAIT. If spi_busy=1, hold in SEND with spi_start=0.
- spi_data_in is valid whenever spi_start=1:
  - k=0: {rw, addr_q}.
  - k>=1, read: 8'h00.
  - k>=1, write: buf[k-1].
- WAIT: wait for spi_new_data=1.
  - If k>=1 and rw_q=1, write spi_data_out to buf[k-1].
  - If k==len_q, go to CS_HOLD; otherwise increment k and go to SEND.
- CS_HOLD: count CS_DELAY cycles. Then drive cs_n to 1, pulse done, and go to GAP.
- GAP: count CS_DELAY cycles, then go to IDLE. req is ignored in GAP.
- Buffer: MAX_BYTES x 8 registers, cleared by rst. Write transactions never modify the buffer. Read data becomes visible on rd_byte the cycle after capture.
- Host writes with wr_en while busy=1 are dropped; the buffer is unchanged.

## Timing
- Reset values:
  - cs_n=1, busy=0, done=0, spi_start=0, spi_data_in=0.
  - State IDLE, all buffer bytes 0.
- A rst asserted mid-transaction takes priority: the next edge forces all of the above, including cs_n=1. No done pulse is generated.
- Acceptance: req sampled at edge E makes cs_n=0 and busy=1 from E+1.
- The first spi_start is asserted at E+1+CS_DELAY, provided spi_busy=0.
- Inter-byte gap: spi_new_data seen at edge N produces the next spi_start at N+1. This is one idle cycle on the engine side.
- The final spi_new_data at edge F gives:
  - cs_n=1 and done=1 at F+1+CS_DELAY;
  - busy=0 at F+1+2*CS_DELAY.
- A req is accepted in the same cycle busy is low.
- spi_new_data arriving outside WAIT is ignored.
- The transaction always issues exactly len_q+1 spi_start pulses.
- k is 4 bits wide, never exceeds MAX_BYTES and never wraps.

## Test plan
- Reset mid-read: rst held 1 cycle during byte 2. Required: cs_n=1 next cycle, no done pulse, buffer all 0x00, and the next req runs normally.
- Write 3 bytes: preload buf=0xA1,0xB2,0xC3, then req rw=0, addr=0x1B, len=3. Required: engine sees 0x1B,0xA1,0xB2,0xC3; cs_n low over all 4 bytes; single done; buffer unchanged.
- Read 2 bytes: slave model returns 0x5A,0x3C after the address byte; req rw=1, addr=0x75, len=2. Required: engine sees 0xF5,0x00,0x00; rd_byte[0]=0x5A, rd_byte[1]=0x3C.
- Address-only: req len=0. Required: one spi_start with 0x.., cs_n low for exactly setup+byte+hold cycles, done pulses once.
- Clamp and engine stall: req len=12 with MAX_BYTES=8, engine model holding spi_busy=1 for 5 cycles before each byte. Required: exactly 9 spi_start pulses, none asserted while spi_busy=1.
- Busy protection: wr_en and req pulsed mid-transaction and during GAP. Required: buffer unchanged, no second transaction, cs_n high for at least CS_DELAY cycles between transactions.
